// File: rtl/jt89_wr_sched.sv
// rtl/jt89_wr_sched.sv - round-robin write scheduler serialising register commands onto the jt89 wr_n/din port
// Optional feature macro: JT89_WR_SCHED_SHADOW_EN (shadow copy of PSG registers, skips redundant bytes)
module jt89_wr_sched #(
  parameter int WR_LOW = 2,
  parameter int WR_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_reg,
  input  logic [9:0] req0_val,
  output logic       req0_ready,
  output logic       req0_done,
  input  logic       req1_valid,
  input  logic [2:0] req1_reg,
  input  logic [9:0] req1_val,
  output logic       req1_ready,
  output logic       req1_done,
  output logic       wr_n,
  output logic [7:0] din,
  output logic       busy
);

  // A zero parameter would underflow the counter load, so clamp it to one cycle.
  localparam int LOW_N = (WR_LOW < 1) ? 1 : WR_LOW;
  localparam int GAP_N = (WR_GAP < 1) ? 1 : WR_GAP;
  localparam logic [3:0] LOW_LD = 4'(LOW_N - 1);
  localparam logic [3:0] GAP_LD = 4'(GAP_N - 1);

  typedef enum logic [2:0] {IDLE, LOW1, GAP1, LOW2, GAP2} state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       last_gnt;   // 1 after reset so that req0 wins the first contested grant
  logic       cur_id;
  logic       two_byte;
  logic [7:0] data_byte;

  logic       gnt_any;
  logic       gnt_id;
  logic [2:0] sel_reg;
  logic [9:0] sel_val;
  logic [7:0] sel_latch;
  logic [7:0] sel_data;
  logic       sel_two;
  logic       skip_all;
  logic       hi_same;
  logic       done_pulse;

  // Arbitration and byte encoding for the command being offered in IDLE.
  always_comb begin
    gnt_any   = !rst && (state == IDLE) && (req0_valid || req1_valid);
    gnt_id    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
    sel_reg   = gnt_id ? req1_reg : req0_reg;
    sel_val   = gnt_id ? req1_val : req0_val;
    sel_latch = (sel_reg == 3'b110) ? {4'b1110, 1'b0, sel_val[2:0]}
                                    : {1'b1, sel_reg, sel_val[3:0]};
    sel_data  = {2'b00, sel_val[9:4]};
    sel_two   = !sel_reg[0] && (sel_reg[2:1] != 2'd3);
  end

`ifdef JT89_WR_SCHED_SHADOW_EN
  logic [3:0] sh_vol  [4];
  logic [9:0] sh_tone [4];   // entry 3 is never used: channel 3 is the noise control
  logic [2:0] sh_ctrl;
  logic [2:0] cur_reg;
  logic [9:0] cur_val;

  // Compare the offered command against what the PSG already holds.
  always_comb begin
    skip_all = 1'b0;
    hi_same  = 1'b0;
    if (sel_reg[0])
      skip_all = (sh_vol[sel_reg[2:1]] == sel_val[3:0]);
    else if (sel_reg[2:1] == 2'd3)
      skip_all = (sh_ctrl == sel_val[2:0]);
    else begin
      skip_all = (sh_tone[sel_reg[2:1]] == sel_val);
      hi_same  = (sh_tone[sel_reg[2:1]][9:4] == sel_val[9:4]);
    end
  end

  // Shadow tracks each byte once its low phase completes, i.e. once the PSG has seen it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sh_vol[i]  <= 4'hF;
        sh_tone[i] <= 10'h000;
      end
      sh_ctrl <= 3'b100;
      cur_reg <= 3'b000;
      cur_val <= 10'h000;
    end else begin
      if (gnt_any) begin
        cur_reg <= sel_reg;
        cur_val <= sel_val;
      end
      if (state == LOW1 && cnt == 4'd0) begin
        if (cur_reg[0])
          sh_vol[cur_reg[2:1]] <= cur_val[3:0];
        else if (cur_reg[2:1] == 2'd3)
          sh_ctrl <= cur_val[2:0];
        else
          sh_tone[cur_reg[2:1]][3:0] <= cur_val[3:0];
      end
      if (state == LOW2 && cnt == 4'd0)
        sh_tone[cur_reg[2:1]][9:4] <= cur_val[9:4];
    end
  end
`else
  assign skip_all = 1'b0;
  assign hi_same  = 1'b0;
`endif

  // Done fires in the final gap cycle; a skipped command lands directly on that cycle.
  always_comb begin
    done_pulse = (state == GAP2 && cnt == 4'd0) ||
                 (state == GAP1 && cnt == 4'd0 && !two_byte);
    req0_ready = gnt_any && !gnt_id;
    req1_ready = gnt_any &&  gnt_id;
    req0_done  = done_pulse && !cur_id;
    req1_done  = done_pulse &&  cur_id;
    busy       = (state != IDLE);
  end

  // Byte sequencer: wr_n and din are registered so din never changes inside a low window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      wr_n      <= 1'b1;
      din       <= 8'h00;
      last_gnt  <= 1'b1;
      cur_id    <= 1'b0;
      two_byte  <= 1'b0;
      data_byte <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            last_gnt  <= gnt_id;
            cur_id    <= gnt_id;
            data_byte <= sel_data;
            two_byte  <= sel_two && !hi_same;
            if (skip_all) begin
              state <= GAP2;
              cnt   <= 4'd0;
            end else begin
              state <= LOW1;
              cnt   <= LOW_LD;
              wr_n  <= 1'b0;
              din   <= sel_latch;
            end
          end
        end
        LOW1: begin
          if (cnt == 4'd0) begin
            state <= GAP1;
            cnt   <= GAP_LD;
            wr_n  <= 1'b1;
          end else cnt <= cnt - 4'd1;
        end
        GAP1: begin
          if (cnt == 4'd0) begin
            if (two_byte) begin
              state <= LOW2;
              cnt   <= LOW_LD;
              wr_n  <= 1'b0;
              din   <= data_byte;
            end else state <= IDLE;
          end else cnt <= cnt - 4'd1;
        end
        LOW2: begin
          if (cnt == 4'd0) begin
            state <= GAP2;
            cnt   <= GAP_LD;
            wr_n  <= 1'b1;
          end else cnt <= cnt - 4'd1;
        end
        GAP2: begin
          if (cnt == 4'd0) state <= IDLE;
          else cnt <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt89_wr_sched.sv
// tb/tb_jt89_wr_sched.sv - directed self-checking bench for jt89_wr_sched (WR_LOW=2, WR_GAP=2)
module tb_jt89_wr_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_reg, req1_reg;
  logic [9:0] req0_val, req1_val;
  logic       req0_ready, req0_done, req1_ready, req1_done;
  logic       wr_n, busy;
  logic [7:0] din;

  int checks = 0;
  int failures = 0;

  logic [7:0] cap[$];
  logic       prev_wr = 1'b1;
  int         done0_cnt = 0;

  jt89_wr_sched #(.WR_LOW(2), .WR_GAP(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_val(req0_val),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_val(req1_val),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .wr_n(wr_n), .din(din), .busy(busy)
  );

  always #5 clk = ~clk;

  // Capture the byte present at each wr_n falling edge, as the PSG would.
  always @(negedge clk) begin
    if (prev_wr && !wr_n) cap.push_back(din);
    prev_wr = wr_n;
    if (req0_done) done0_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command at the current cycle (cycle 0) and return the cycle its done pulse appears.
  task automatic run_cmd(input int id, input logic [2:0] r, input logic [9:0] v, output int dcyc);
    int c;
    logic rdy, dn;
    cap.delete();
    if (id == 0) begin req0_valid = 1; req0_reg = r; req0_val = v; end
    else         begin req1_valid = 1; req1_reg = r; req1_val = v; end
    #1;
    rdy = (id == 0) ? req0_ready : req1_ready;
    chk("ready_c0", rdy, 1);
    dcyc = -1;
    c = 0;
    while (dcyc < 0 && c < 40) begin
      @(posedge clk);
      #1;
      if (c == 0) begin req0_valid = 0; req1_valid = 0; end
      #1;
      c++;
      dn = (id == 0) ? req0_done : req1_done;
      if (dn) dcyc = c;
    end
    chk("done_seen", dcyc >= 0, 1);
  endtask

  initial begin
    int d;
    int g[$];
    int gc[$];
    int c;
    logic [7:0] exp_b[6];

    rst = 1; req0_valid = 0; req1_valid = 0;
    req0_reg = 0; req0_val = 0; req1_reg = 0; req1_val = 0;
    repeat (3) tick();
    chk("rst_wr_n", wr_n, 1);
    chk("rst_din", din, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_done", {req0_done, req1_done}, 0);
    rst = 0;
    tick();

`ifndef JT89_WR_SCHED_SHADOW_EN
    // Volume write: ready t0, low t1-t2 with 0x95, done t4, idle t5.
    req0_valid = 1; req0_reg = 3'b001; req0_val = 10'h005;
    #1;
    chk("vol_ready", req0_ready, 1);
    tick(); req0_valid = 0;
    chk("vol_low1_wr", wr_n, 0);
    chk("vol_low1_din", din, 8'h95);
    tick();
    chk("vol_low2_wr", wr_n, 0);
    tick();
    chk("vol_gap_wr", wr_n, 1);
    chk("vol_gap_din", din, 8'h95);
    tick();
    chk("vol_done_t4", req0_done, 1);
    chk("vol_busy_t4", busy, 1);
    tick();
    chk("vol_busy_t5", busy, 0);
    chk("vol_done_t5", req0_done, 0);

    // Tone on channel 2 from req1: two bytes, done at cycle 8.
    run_cmd(1, 3'b100, 10'h2A7, d);
    chk("tone_done_cyc", d, 8);
    chk("tone_nbytes", cap.size(), 2);
    chk("tone_b0", cap[0], 8'hC7);
    chk("tone_b1", cap[1], 8'h2A);
    tick();

    // Noise control: single byte 0xE5.
    run_cmd(0, 3'b110, 10'h3FD, d);
    chk("noise_done_cyc", d, 4);
    chk("noise_nbytes", cap.size(), 1);
    chk("noise_b0", cap[0], 8'hE5);
    tick();

    // Both requesters continuously valid from reset: 0,1,0,1 with tone pairs intact.
    rst = 1; tick(); rst = 0; tick();
    cap.delete();
    req0_valid = 1; req0_reg = 3'b000; req0_val = 10'h155;
    req1_valid = 1; req1_reg = 3'b011; req1_val = 10'h007;
    c = 0;
    while (g.size() < 4 && c < 80) begin
      #1;
      if (req0_ready) begin g.push_back(0); gc.push_back(c); end
      if (req1_ready) begin g.push_back(1); gc.push_back(c); end
      tick();
      c++;
    end
    req0_valid = 0; req1_valid = 0;
    c = 0;
    while (busy && c < 40) begin tick(); c++; end
    chk("rr_ngrants", g.size(), 4);
    if (g.size() == 4) begin
      chk("rr_g0", g[0], 0);
      chk("rr_g1", g[1], 1);
      chk("rr_g2", g[2], 0);
      chk("rr_g3", g[3], 1);
      chk("rr_c1", gc[1], 9);
      chk("rr_c2", gc[2], 14);
      chk("rr_c3", gc[3], 23);
    end
    exp_b = '{8'h85, 8'h15, 8'hB7, 8'h85, 8'h15, 8'hB7};
    chk("rr_nbytes", cap.size(), 6);
    for (int i = 0; i < 6 && i < cap.size(); i++) chk("rr_byte", cap[i], exp_b[i]);
    tick();

    // Reset in the middle of LOW2 of a tone write.
    d = done0_cnt;
    req0_valid = 1; req0_reg = 3'b100; req0_val = 10'h2A7;
    tick(); req0_valid = 0;
    repeat (4) tick();
    chk("mid_low2_wr", wr_n, 0);
    chk("mid_low2_din", din, 8'h2A);
    rst = 1;
    tick();
    chk("mid_rst_wr", wr_n, 1);
    chk("mid_rst_busy", busy, 0);
    rst = 0;
    repeat (3) tick();
    chk("mid_no_done", done0_cnt, d);
    run_cmd(1, 3'b101, 10'h00A, d);
    chk("post_done_cyc", d, 4);
    chk("post_nbytes", cap.size(), 1);
    chk("post_b0", cap[0], 8'hDA);
    tick();
`else
    // Volume equal to reset shadow: no byte, done one cycle after ready.
    run_cmd(0, 3'b001, 10'h00F, d);
    chk("sh_vol_done", d, 1);
    chk("sh_vol_nbytes", cap.size(), 0);
    tick();
    run_cmd(0, 3'b000, 10'h123, d);
    chk("sh_t1_done", d, 8);
    chk("sh_t1_nbytes", cap.size(), 2);
    chk("sh_t1_b0", cap[0], 8'h83);
    chk("sh_t1_b1", cap[1], 8'h12);
    tick();
    run_cmd(0, 3'b000, 10'h12F, d);
    chk("sh_t2_done", d, 4);
    chk("sh_t2_nbytes", cap.size(), 1);
    chk("sh_t2_b0", cap[0], 8'h8F);
    tick();
    run_cmd(1, 3'b000, 10'h12F, d);
    chk("sh_t3_done", d, 1);
    chk("sh_t3_nbytes", cap.size(), 0);
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
